route_request_ctrl: RTL and testbench
=====================================

ROUTE_REQUEST_CTRL -- requirements
Module: route_request_ctrl

Interface
REQ-001 SHALL have parameter PORT_ID, default 0; one-hot index of the input port this block serves (0=L, 1=N, 2=E, 3=S, 4=W).
REQ-002 SHALL have parameter LOCAL_X, default 0; router X coordinate (1 bit).
REQ-003 SHALL have parameter LOCAL_Y, default 0; router Y coordinate (1 bit).
REQ-004 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1; reset, synchronous, active-high.
REQ-006 SHALL have port fifo_empty, input, 1; input FIFO empty, first-word-fall-through.
REQ-007 SHALL have port fifo_flit, input, 32; FIFO head flit, [31:29] type, header [28:17] length, [16] dest X, [15] dest Y.
REQ-008 SHALL have port fifo_rd_en, output, 1; pop FIFO head.
REQ-009 SHALL have port gnt, input, 1; arbiter of the requested output currently selects this port.
REQ-010 SHALL have port out_ready, input, 1; downstream accepts a flit this cycle.
REQ-011 SHALL have port req, output, 5; one-hot output-port request {W,S,E,N,L}.
REQ-012 SHALL have port flit_out, output, 32, forwarded flit, and flit_valid, output, 1, forward strobe.
REQ-013 SHALL have ports flit_type_out, output, 3, and length_out, output, 12; type of current head flit and registered header length, fed to arbiter timer.
REQ-014 SHALL have ports err_seq, err_route, err_len, output, 1 each; single-cycle error pulses, and busy, output, 1.

Function
REQ-015 Flit types SHALL be HEADER=3'b001, BODY=3'b010, TAIL=3'b100; length counts all flits incl. header and tail.
REQ-016 FSM SHALL be one-hot, states IDLE, ROUTE, WAIT_GNT, FORWARD.
REQ-017 IDLE: if !fifo_empty and head type==HEADER -> ROUTE, latching length and dest; if !fifo_empty and type!=HEADER -> pop (fifo_rd_en=1), err_seq pulse, stay IDLE.
REQ-018 ROUTE: XY routing: dx>LOCAL_X ->E; dx<LOCAL_X ->W; else dy>LOCAL_Y ->S; dy<LOCAL_Y ->N; else L; result registered into req, -> WAIT_GNT; req asserted exactly 2 cycles after header first seen in IDLE.
REQ-019 ROUTE: if computed port == PORT_ID (U-turn) SHALL enter drop mode: req stays 0, err_route pulse, -> FORWARD with output suppressed (flits popped, flit_valid=0).
REQ-020 WAIT_GNT: req held; gnt=1 -> FORWARD next cycle; no timeout.
REQ-021 FORWARD: fifo_rd_en = flit_valid = gnt & !fifo_empty & out_ready (drop mode: !fifo_empty only); flit_out = fifo_flit combinationally, zero-latency.
REQ-022 FORWARD: 12-bit flit counter increments per pop, cleared on entry to ROUTE; wrap at 4095 permitted, no saturation.
REQ-023 On popping a TAIL flit: req cleared next cycle, -> IDLE; err_len pulses same cycle if counter+1 != latched length.
REQ-024 gnt deasserted mid-packet SHALL stall popping while keeping req asserted; no flit lost or duplicated.
REQ-025 flit_type_out SHALL equal fifo_flit[31:29] when !fifo_empty, else 0; length_out holds latched length until next header.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Header popped in IDLE with fifo_empty toggling SHALL never be popped twice; only FORWARD pops valid packet flits.

Reset
REQ-028 On rst: state IDLE, req=0, fifo_rd_en=0, flit_valid=0, counter=0, length_out=0, all err_* =0, busy=0.
REQ-029 Reset mid-packet SHALL abandon packet without popping; FIFO contents untouched; no error pulse.

Structure
REQ-030 Flit type codes, field bit positions, port indices and state encodings SHALL live in the shared parameters include.
REQ-031 XY decision SHALL be a combinational sub-module xy_route_calc (inputs dest X/Y, outputs 5-bit one-hot).

Verification
REQ-032 LOCAL=(0,0), PORT_ID=0, header dest (1,0) len 3 + body + tail, gnt tied 1 -> req=5'b00100 two cycles after header, 3 flit_valid pulses, req=0 after tail, no errors.
REQ-033 Same packet, gnt dropped 2 cycles after first pop -> popping stalls, req held, resumes on gnt, exactly 3 flits out.
REQ-034 PORT_ID=2 (E), dest (1,0) -> err_route pulse, req stays 0, 3 flits popped, flit_valid never 1.
REQ-035 BODY flit at head in IDLE -> one pop, err_seq pulse, stays IDLE.
REQ-036 Header length 5 but tail at 3rd flit -> err_len pulse on tail pop, return IDLE.
REQ-037 rst asserted during FORWARD after 1 pop -> next cycle req=0, IDLE, fifo_rd_en=0.

Source files
------------

// File: rtl/route_request_ctrl_pkg.sv
// Shared constants for the input-port route/request controller: flit field
// layout, flit type codes, output-port indices and the one-hot FSM encoding.
package route_request_ctrl_pkg;

  localparam int FLIT_W    = 32;
  localparam int LEN_W     = 12;
  localparam int NUM_PORTS = 5;

  localparam int TYPE_HI    = 31;
  localparam int TYPE_LO    = 29;
  localparam int LEN_HI     = 28;
  localparam int LEN_LO     = 17;
  localparam int DEST_X_BIT = 16;
  localparam int DEST_Y_BIT = 15;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  // Output-port indices; req is one-hot {W,S,E,N,L}.
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ROUTE    = 4'b0010,
    ST_WAIT_GNT = 4'b0100,
    ST_FORWARD  = 4'b1000
  } state_e;

  function automatic logic [2:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[TYPE_HI:TYPE_LO];
  endfunction

endpackage

// File: rtl/route_request_ctrl_if.sv
// FIFO, arbiter and downstream signals of one router input port.
// master = the controller, slave = FIFO/arbiter/downstream environment.
interface route_request_ctrl_if;
  import route_request_ctrl_pkg::*;

  logic                 fifo_empty;
  logic [FLIT_W-1:0]    fifo_flit;
  logic                 fifo_rd_en;
  logic                 gnt;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] req;
  logic [FLIT_W-1:0]    flit_out;
  logic                 flit_valid;
  logic [2:0]           flit_type_out;
  logic [LEN_W-1:0]     length_out;

  modport master (
    input  fifo_empty, fifo_flit, gnt, out_ready,
    output fifo_rd_en, req, flit_out, flit_valid, flit_type_out, length_out
  );

  modport slave (
    output fifo_empty, fifo_flit, gnt, out_ready,
    input  fifo_rd_en, req, flit_out, flit_valid, flit_type_out, length_out
  );

endinterface

// File: rtl/route_request_ctrl_xy_route_calc.sv
// Dimension-order (X then Y) output-port selection for a 2x2 mesh with
// 1-bit coordinates; purely combinational.
module xy_route_calc
  import route_request_ctrl_pkg::*;
#(
  parameter logic LOCAL_X = 1'b0,
  parameter logic LOCAL_Y = 1'b0
) (
  input  logic                 dest_x,
  input  logic                 dest_y,
  output logic [NUM_PORTS-1:0] port_oh
);

  // With 1-bit coordinates, "greater" means dest=1/local=0 and vice versa.
  logic x_gt, x_lt, y_gt, y_lt;

  assign x_gt = dest_x & ~LOCAL_X;
  assign x_lt = ~dest_x & LOCAL_X;
  assign y_gt = dest_y & ~LOCAL_Y;
  assign y_lt = ~dest_y & LOCAL_Y;

  always_comb begin
    port_oh = '0;
    if (x_gt)      port_oh[PORT_E] = 1'b1;
    else if (x_lt) port_oh[PORT_W] = 1'b1;
    else if (y_gt) port_oh[PORT_S] = 1'b1;
    else if (y_lt) port_oh[PORT_N] = 1'b1;
    else           port_oh[PORT_L] = 1'b1;
  end

endmodule

// File: rtl/route_request_ctrl.sv
// Input-port controller: routes each packet header, requests the output port,
// forwards flits while granted, and drops U-turn packets.
module route_request_ctrl
  import route_request_ctrl_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter logic        LOCAL_X = 1'b0,
  parameter logic        LOCAL_Y = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  route_request_ctrl_if.master bus,
  output logic                 err_seq,
  output logic                 err_route,
  output logic                 err_len,
  output logic                 busy
);

  localparam logic [NUM_PORTS-1:0] PORT_MASK = NUM_PORTS'(1 << PORT_ID);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] req_q, req_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 dest_x_q, dest_x_d;
  logic                 dest_y_q, dest_y_d;
  logic                 drop_q, drop_d;

  logic [NUM_PORTS-1:0] route_oh;
  logic [2:0]           head_type;
  logic                 pop, fwd;

  xy_route_calc #(
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y)
  ) u_xy_route_calc (
    .dest_x  (dest_x_q),
    .dest_y  (dest_y_q),
    .port_oh (route_oh)
  );

  assign head_type = bus.fifo_empty ? 3'b000 : flit_type(bus.fifo_flit);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    req_d     = req_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    dest_x_d  = dest_x_q;
    dest_y_d  = dest_y_q;
    drop_d    = drop_q;
    pop       = 1'b0;
    err_seq   = 1'b0;
    err_route = 1'b0;
    err_len   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The header stays in the FIFO; it is popped later as packet flit 1.
        if (!bus.fifo_empty) begin
          if (head_type == FLIT_HEADER) begin
            state_d  = ST_ROUTE;
            len_d    = bus.fifo_flit[LEN_HI:LEN_LO];
            dest_x_d = bus.fifo_flit[DEST_X_BIT];
            dest_y_d = bus.fifo_flit[DEST_Y_BIT];
            cnt_d    = '0;
          end else begin
            pop     = 1'b1;
            err_seq = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        if (|(route_oh & PORT_MASK)) begin
          drop_d    = 1'b1;
          req_d     = '0;
          err_route = 1'b1;
          state_d   = ST_FORWARD;
        end else begin
          drop_d  = 1'b0;
          req_d   = route_oh;
          state_d = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (bus.gnt) state_d = ST_FORWARD;
      end
      ST_FORWARD: begin
        pop = drop_q ? !bus.fifo_empty
                     : (bus.gnt && !bus.fifo_empty && bus.out_ready);
        if (pop) begin
          cnt_d = cnt_q + 1'b1;
          if (head_type == FLIT_TAIL) begin
            state_d = ST_IDLE;
            req_d   = '0;
            drop_d  = 1'b0;
            err_len = (cnt_d != len_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
        drop_d  = 1'b0;
      end
    endcase

    // A reset cycle must neither consume FIFO data nor flag errors.
    if (rst) begin
      pop       = 1'b0;
      err_seq   = 1'b0;
      err_route = 1'b0;
      err_len   = 1'b0;
    end

    fwd = pop && (state_q == ST_FORWARD) && !drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      dest_x_q <= 1'b0;
      dest_y_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      req_q    <= req_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      dest_x_q <= dest_x_d;
      dest_y_q <= dest_y_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.fifo_rd_en    = pop;
  assign bus.flit_valid    = fwd;
  assign bus.flit_out      = bus.fifo_flit;
  assign bus.req           = req_q;
  assign bus.flit_type_out = head_type;
  assign bus.length_out    = len_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_route_request_ctrl.sv
// Self-checking bench: queue-based FIFO models feed two controllers
// (PORT_ID 0 and PORT_ID 2); forwarded flits are checked against a scoreboard.
module tb_route_request_ctrl;
  import route_request_ctrl_pkg::*;

  typedef struct {
    logic [31:0] flit;
    logic [4:0]  req;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  route_request_ctrl_if if0();
  route_request_ctrl_if if1();
  logic err_seq0, err_route0, err_len0, busy0;
  logic err_seq1, err_route1, err_len1, busy1;

  route_request_ctrl #(.PORT_ID(0), .LOCAL_X(1'b0), .LOCAL_Y(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0),
    .err_seq(err_seq0), .err_route(err_route0), .err_len(err_len0), .busy(busy0)
  );

  route_request_ctrl #(.PORT_ID(2), .LOCAL_X(1'b0), .LOCAL_Y(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .err_seq(err_seq1), .err_route(err_route1), .err_len(err_len1), .busy(busy1)
  );

  logic [31:0] fq0[$], fq1[$];
  exp_t        exp0[$];

  int n_checks = 0;
  int n_pass   = 0;

  int vcnt0, eseq0, eroute0, elen0, elen_tail0, ready_viol0;
  int vcnt1, eroute1, eoth1, rdcnt1;
  logic [4:0] req_or1;
  logic s_rd0, s_rd1;
  logic [4:0] s_req0;
  logic s_busy0;

  task automatic drive_fifo();
    if0.fifo_empty = (fq0.size() == 0);
    if0.fifo_flit  = (fq0.size() == 0) ? 32'h0 : fq0[0];
    if1.fifo_empty = (fq1.size() == 0);
    if1.fifo_flit  = (fq1.size() == 0) ? 32'h0 : fq1[0];
  endtask

  task automatic clr_mon();
    vcnt0 = 0; eseq0 = 0; eroute0 = 0; elen0 = 0; elen_tail0 = 0; ready_viol0 = 0;
    vcnt1 = 0; eroute1 = 0; eoth1 = 0; rdcnt1 = 0; req_or1 = '0;
  endtask

  // One clock: sample outputs at the falling edge, then let the FIFO models
  // pop just after the rising edge and present the new heads.
  task automatic cycle();
    exp_t        e;
    logic [31:0] head, tmp;
    logic [2:0]  want_type;
    @(negedge clk);
    s_rd0   = if0.fifo_rd_en;
    s_rd1   = if1.fifo_rd_en;
    s_req0  = if0.req;
    s_busy0 = busy0;
    head    = (fq0.size() == 0) ? 32'h0 : fq0[0];
    if (if0.flit_valid) begin
      vcnt0++;
      if (!if0.out_ready || !if0.gnt) ready_viol0++;
      n_checks++;
      if (exp0.size() == 0)
        $display("FAIL sb0_extra: got flit %h req %b, want no flit", if0.flit_out, if0.req);
      else begin
        e = exp0.pop_front();
        if ({if0.flit_out, if0.req} !== {e.flit, e.req})
          $display("FAIL sb0_flit: got flit %h req %b, want flit %h req %b",
                   if0.flit_out, if0.req, e.flit, e.req);
        else n_pass++;
      end
    end
    if (err_seq0)   eseq0++;
    if (err_route0) eroute0++;
    if (err_len0) begin
      elen0++;
      if (s_rd0 && head[31:29] == FLIT_TAIL) elen_tail0++;
    end
    want_type = (fq0.size() == 0) ? 3'b000 : head[31:29];
    n_checks++;
    if (if0.flit_type_out !== want_type)
      $display("FAIL flit_type_out: got %b, want %b", if0.flit_type_out, want_type);
    else n_pass++;
    req_or1 |= if1.req;
    if (if1.flit_valid) vcnt1++;
    if (s_rd1) rdcnt1++;
    if (err_route1) eroute1++;
    if (err_seq1 || err_len1) eoth1++;
    @(posedge clk);
    #1;
    if (s_rd0 && fq0.size() > 0) tmp = fq0.pop_front();
    if (s_rd1 && fq1.size() > 0) tmp = fq1.pop_front();
    drive_fifo();
  endtask

  task automatic push_pkt(input bit which, input logic [11:0] len, input logic dx,
                          input logic dy, input int nflits, input logic [4:0] req_exp);
    logic [31:0] f;
    exp_t e;
    for (int i = 0; i < nflits; i++) begin
      if (i == 0)               f = {FLIT_HEADER, len, dx, dy, 15'($urandom)};
      else if (i == nflits - 1) f = {FLIT_TAIL, 29'($urandom)};
      else                      f = {FLIT_BODY, 29'($urandom)};
      if (which) fq1.push_back(f);
      else begin
        fq0.push_back(f);
        if (req_exp != 5'b0) begin
          e.flit = f; e.req = req_exp;
          exp0.push_back(e);
        end
      end
    end
    drive_fifo();
  endtask

  task automatic run_until_idle(input bit which, input int budget, input bit rand_ready,
                                input string name);
    bit done = 1'b0;
    int n    = 0;
    while (!done && n < budget) begin
      if (rand_ready) if0.out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
      done = which ? (!busy1 && fq1.size() == 0) : (!busy0 && fq0.size() == 0);
    end
    if0.out_ready = 1'b1;
    n_checks++;
    if (!done) $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, budget);
    else n_pass++;
  endtask

  task automatic wait_pops0(input int target, input int budget, input string name);
    int n = 0;
    while (vcnt0 < target && n < budget) begin
      cycle();
      n++;
    end
    n_checks++;
    if (vcnt0 < target) $display("FAIL %s_timeout: got %0d pops, want %0d", name, vcnt0, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++; if (if0.req !== 5'b0) $display("FAIL rst_req: got %b, want 0", if0.req); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL rst_busy: got %b, want 0", busy0); else n_pass++;
    n_checks++; if (if0.fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b, want 0", if0.fifo_rd_en); else n_pass++;
    n_checks++; if (if0.flit_valid !== 1'b0) $display("FAIL rst_valid: got %b, want 0", if0.flit_valid); else n_pass++;
    n_checks++; if (if0.length_out !== 12'd0) $display("FAIL rst_length: got %0d, want 0", if0.length_out); else n_pass++;
    n_checks++;
    if ({err_seq0, err_route0, err_len0} !== 3'b000)
      $display("FAIL rst_err: got %b, want 000", {err_seq0, err_route0, err_len0});
    else n_pass++;
    n_checks++; if ({busy1, if1.req} !== 6'b0) $display("FAIL rst_dut1: got %b, want 0", {busy1, if1.req}); else n_pass++;
  endtask

  task automatic test_basic();
    clr_mon();
    if0.gnt = 1'b1; if0.out_ready = 1'b1;
    push_pkt(1'b0, 12'd3, 1'b1, 1'b0, 3, 5'b00100);
    cycle();
    n_checks++; if ({s_req0, s_rd0} !== 6'b0) $display("FAIL basic_idle: got req %b rd %b, want 0 0", s_req0, s_rd0); else n_pass++;
    cycle();
    n_checks++; if ({s_req0, s_busy0} !== 6'b000001) $display("FAIL basic_route: got req %b busy %b, want 0 1", s_req0, s_busy0); else n_pass++;
    cycle();
    n_checks++; if (s_req0 !== 5'b00100) $display("FAIL basic_req_latency: got %b, want 00100", s_req0); else n_pass++;
    run_until_idle(1'b0, 20, 1'b0, "basic");
    n_checks++; if (vcnt0 != 3) $display("FAIL basic_pops: got %0d, want 3", vcnt0); else n_pass++;
    n_checks++; if (if0.req !== 5'b0) $display("FAIL basic_req_clear: got %b, want 0", if0.req); else n_pass++;
    n_checks++; if (eseq0 + eroute0 + elen0 != 0) $display("FAIL basic_err: got %0d pulses, want 0", eseq0 + eroute0 + elen0); else n_pass++;
    n_checks++; if (if0.length_out !== 12'd3) $display("FAIL basic_length: got %0d, want 3", if0.length_out); else n_pass++;
  endtask

  task automatic test_gnt_stall();
    clr_mon();
    if0.gnt = 1'b1;
    push_pkt(1'b0, 12'd3, 1'b1, 1'b0, 3, 5'b00100);
    wait_pops0(1, 20, "stall_first");
    cycle();
    if0.gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (s_req0 !== 5'b00100) $display("FAIL stall_req_held: got %b, want 00100", s_req0); else n_pass++;
    end
    n_checks++; if (vcnt0 != 2) $display("FAIL stall_pops: got %0d, want 2", vcnt0); else n_pass++;
    if0.gnt = 1'b1;
    run_until_idle(1'b0, 20, 1'b0, "stall");
    n_checks++; if (vcnt0 != 3 || exp0.size() != 0) $display("FAIL stall_total: got %0d pops %0d pending, want 3 0", vcnt0, exp0.size()); else n_pass++;
  endtask

  task automatic test_uturn();
    clr_mon();
    if1.gnt = 1'b0; if1.out_ready = 1'b1;
    push_pkt(1'b1, 12'd3, 1'b1, 1'b0, 3, 5'b0);
    run_until_idle(1'b1, 20, 1'b0, "uturn");
    n_checks++; if (eroute1 != 1) $display("FAIL uturn_err_route: got %0d pulses, want 1", eroute1); else n_pass++;
    n_checks++; if (req_or1 !== 5'b0) $display("FAIL uturn_req: got %b, want 0", req_or1); else n_pass++;
    n_checks++; if (rdcnt1 != 3) $display("FAIL uturn_pops: got %0d, want 3", rdcnt1); else n_pass++;
    n_checks++; if (vcnt1 != 0 || eoth1 != 0) $display("FAIL uturn_valid: got %0d valid %0d err, want 0 0", vcnt1, eoth1); else n_pass++;
  endtask

  task automatic test_seq_err();
    logic [31:0] f;
    clr_mon();
    f = {FLIT_BODY, 29'($urandom)};
    fq0.push_back(f);
    drive_fifo();
    cycle();
    n_checks++; if ({s_rd0, s_busy0} !== 2'b10) $display("FAIL seq_pop: got rd %b busy %b, want 1 0", s_rd0, s_busy0); else n_pass++;
    cycle();
    n_checks++; if (eseq0 != 1 || fq0.size() != 0) $display("FAIL seq_err: got %0d pulses %0d left, want 1 0", eseq0, fq0.size()); else n_pass++;
    n_checks++; if (s_busy0 !== 1'b0 || vcnt0 != 0) $display("FAIL seq_idle: got busy %b valid %0d, want 0 0", s_busy0, vcnt0); else n_pass++;
  endtask

  task automatic test_len_err();
    clr_mon();
    if0.gnt = 1'b1;
    push_pkt(1'b0, 12'd5, 1'b1, 1'b0, 3, 5'b00100);
    run_until_idle(1'b0, 20, 1'b0, "len");
    n_checks++; if (elen0 != 1 || elen_tail0 != 1) $display("FAIL len_err: got %0d pulses %0d on tail, want 1 1", elen0, elen_tail0); else n_pass++;
    n_checks++; if (vcnt0 != 3 || busy0 !== 1'b0) $display("FAIL len_done: got %0d pops busy %b, want 3 0", vcnt0, busy0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_mon();
    if0.gnt = 1'b1;
    push_pkt(1'b0, 12'd3, 1'b0, 1'b1, 3, 5'b01000);
    wait_pops0(1, 20, "rstmid_first");
    rst = 1'b1;
    cycle();
    n_checks++; if (s_rd0 !== 1'b0) $display("FAIL rstmid_no_pop: got rd %b, want 0", s_rd0); else n_pass++;
    n_checks++; if ({if0.req, busy0, if0.fifo_rd_en} !== 7'b0) $display("FAIL rstmid_state: got req %b busy %b rd %b, want 0", if0.req, busy0, if0.fifo_rd_en); else n_pass++;
    n_checks++; if (fq0.size() != 2 || eseq0 + eroute0 + elen0 != 0) $display("FAIL rstmid_fifo: got %0d left %0d err, want 2 0", fq0.size(), eseq0 + eroute0 + elen0); else n_pass++;
    fq0.delete();
    exp0.delete();
    drive_fifo();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    clr_mon();
    if0.gnt = 1'b1;
    push_pkt(1'b0, 12'd4, 1'b0, 1'b1, 4, 5'b01000);
    push_pkt(1'b0, 12'd2, 1'b1, 1'b1, 2, 5'b00100);
    run_until_idle(1'b0, 80, 1'b1, "b2b");
    n_checks++; if (vcnt0 != 6 || exp0.size() != 0) $display("FAIL b2b_pops: got %0d pops %0d pending, want 6 0", vcnt0, exp0.size()); else n_pass++;
    n_checks++; if (ready_viol0 != 0) $display("FAIL b2b_ready: got %0d pops without ready, want 0", ready_viol0); else n_pass++;
    n_checks++; if (eseq0 + eroute0 + elen0 != 0) $display("FAIL b2b_err: got %0d pulses, want 0", eseq0 + eroute0 + elen0); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    if0.gnt = 1'b0; if0.out_ready = 1'b1;
    if1.gnt = 1'b0; if1.out_ready = 1'b1;
    drive_fifo();
    clr_mon();
    repeat (2) cycle();
    test_reset();
    rst = 1'b0;
    cycle();
    test_basic();
    test_gnt_stall();
    test_uturn();
    test_seq_err();
    test_len_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
